// File: rtl/z80_bus_arbiter.sv
// Z80 external bus arbiter: hands the bus to an nBUSREQ/nBUSACK master at
// M-cycle boundaries, stalls the core meanwhile and polices grant length.
module z80_bus_arbiter #(
  parameter int SYNC_STAGES       = 2,
  parameter int MIN_CPU_GAP       = 0,
  parameter int MAX_GRANT_TCYCLES = 1024,
  parameter int COUNT_W           = 16
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               nBUSREQ,
  input  logic               mcycle_done,
  output logic               nBUSACK,
  output logic               bus_float,
  output logic               core_stall,
  output logic [COUNT_W-1:0] grant_count,
  output logic               timeout
);

  localparam int GAP_W = (MIN_CPU_GAP > 0) ? $clog2(MIN_CPU_GAP + 1) : 1;
  localparam int TMR_W = (MAX_GRANT_TCYCLES > 0) ? $clog2(MAX_GRANT_TCYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(MIN_CPU_GAP);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(MAX_GRANT_TCYCLES);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam bit                 TMO_EN    = (MAX_GRANT_TCYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   eligible_s;
  logic                   stall_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [GAP_W-1:0]       cooldown_r;
  logic [GAP_W-1:0]       cooldown_nxt_s;
  logic [TMR_W-1:0]       timer_r;
  logic [TMR_W-1:0]       timer_nxt_s;
  logic [COUNT_W-1:0]     count_r;
  logic [COUNT_W-1:0]     count_nxt_s;
  logic                   timeout_r;
  logic                   timeout_nxt_s;
  logic                   nbusack_r;
  logic                   bus_float_r;

  // Request synchronizer; resets to "not requesting"
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ~nBUSREQ};
    end
  end

  assign req_s      = sync_r[SYNC_STAGES-1];
  assign eligible_s = req_s & (cooldown_r == {GAP_W{1'b0}});

  // Next-state, bookkeeping and core stall decode
  always_comb begin
    state_nxt_s    = state_r;
    cooldown_nxt_s = cooldown_r;
    timer_nxt_s    = timer_r;
    count_nxt_s    = count_r;
    timeout_nxt_s  = timeout_r;
    stall_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mcycle_done && eligible_s) begin
          // Stall in the decision cycle so the core parks at the boundary
          stall_s     = 1'b1;
          state_nxt_s = ST_GRANTED;
          timer_nxt_s = {TMR_W{1'b0}};
          if (count_r != COUNT_MAX) begin
            count_nxt_s = count_r + COUNT_W'(1);
          end else begin
            count_nxt_s = count_r;
          end
        end else if (mcycle_done && (cooldown_r != {GAP_W{1'b0}})) begin
          cooldown_nxt_s = cooldown_r - GAP_W'(1);
        end else begin
          cooldown_nxt_s = cooldown_r;
        end
      end
      ST_GRANTED: begin
        stall_s = 1'b1;
        if (timer_r != TMR_MAX) begin
          timer_nxt_s = timer_r + TMR_W'(1);
        end else begin
          timer_nxt_s = timer_r;
        end
        if (TMO_EN && (timer_nxt_s == TMR_MAX)) begin
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
        if (!req_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_GRANTED;
        end
      end
      ST_RELEASE: begin
        stall_s        = 1'b1;
        state_nxt_s    = ST_IDLE;
        cooldown_nxt_s = GAP_LOAD;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State registers; bus handshake outputs are decoded from the next state
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r     <= ST_IDLE;
      cooldown_r  <= {GAP_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      count_r     <= {COUNT_W{1'b0}};
      timeout_r   <= 1'b0;
      nbusack_r   <= 1'b1;
      bus_float_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cooldown_r  <= cooldown_nxt_s;
      timer_r     <= timer_nxt_s;
      count_r     <= count_nxt_s;
      timeout_r   <= timeout_nxt_s;
      nbusack_r   <= (state_nxt_s != ST_GRANTED);
      bus_float_r <= (state_nxt_s == ST_GRANTED);
    end
  end

  assign nBUSACK     = nbusack_r;
  assign bus_float   = bus_float_r;
  assign core_stall  = stall_s;
  assign grant_count = count_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: two parameterisations share one stimulus stream
// and are checked every cycle against a behavioural ownership model.
module tb_z80_bus_arbiter;

  localparam int SYNC = 2;
  localparam int A_GAP = 0, A_MAX = 8,    A_CW = 2;
  localparam int B_GAP = 2, B_MAX = 1024, B_CW = 16;

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  logic nBUSREQ = 1'b1;
  logic mcycle_done = 1'b0;

  logic nbusack_a, float_a, stall_a, timeout_a;
  logic nbusack_b, float_b, stall_b, timeout_b;
  logic [A_CW-1:0] count_a;
  logic [B_CW-1:0] count_b;

  int n_checks = 0;
  int n_fail = 0;
  bit checks_on = 1'b0;
  logic stall_a_c, stall_b_c;

  always #5 CLK = ~CLK;

  z80_bus_arbiter #(.SYNC_STAGES(SYNC), .MIN_CPU_GAP(A_GAP),
                    .MAX_GRANT_TCYCLES(A_MAX), .COUNT_W(A_CW)) dut_a (
    .CLK(CLK), .nRESET(nRESET), .nBUSREQ(nBUSREQ), .mcycle_done(mcycle_done),
    .nBUSACK(nbusack_a), .bus_float(float_a), .core_stall(stall_a),
    .grant_count(count_a), .timeout(timeout_a));

  z80_bus_arbiter #(.SYNC_STAGES(SYNC), .MIN_CPU_GAP(B_GAP),
                    .MAX_GRANT_TCYCLES(B_MAX), .COUNT_W(B_CW)) dut_b (
    .CLK(CLK), .nRESET(nRESET), .nBUSREQ(nBUSREQ), .mcycle_done(mcycle_done),
    .nBUSACK(nbusack_b), .bus_float(float_b), .core_stall(stall_b),
    .grant_count(count_b), .timeout(timeout_b));

  // Model: who owns the bus, how many boundaries until the core may yield
  // again, how long the master has held it, and how many grants occurred.
  typedef struct {
    bit [7:0] hist;
    bit       master_owns;
    bit       turnaround;
    int       gap_left;
    int       held;
    int       grants;
    bit       overlong;
  } m_t;
  m_t m [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? A_GAP : B_GAP;
  endfunction
  function automatic int max_of(input int k);
    return (k == 0) ? A_MAX : B_MAX;
  endfunction
  function automatic int cmax_of(input int k);
    return (k == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1);
  endfunction

  function automatic bit wants(input int k);
    return m[k].hist[SYNC-1];
  endfunction

  function automatic bit exp_stall(input int k, input logic md);
    if (m[k].master_owns || m[k].turnaround) return 1'b1;
    return md && wants(k) && (m[k].gap_left == 0);
  endfunction

  task automatic model_reset(input int k);
    m[k].hist = 8'd0; m[k].master_owns = 1'b0; m[k].turnaround = 1'b0;
    m[k].gap_left = 0; m[k].held = 0; m[k].grants = 0; m[k].overlong = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit w;
    w = wants(k);
    if (m[k].master_owns) begin
      m[k].held = (m[k].held + 1 > max_of(k)) ? max_of(k) : m[k].held + 1;
      if (max_of(k) != 0 && m[k].held == max_of(k)) m[k].overlong = 1'b1;
      if (!w) begin
        m[k].master_owns = 1'b0;
        m[k].turnaround = 1'b1;
      end
    end else if (m[k].turnaround) begin
      m[k].turnaround = 1'b0;
      m[k].gap_left = gap_of(k);
    end else if (mcycle_done) begin
      if (w && m[k].gap_left == 0) begin
        m[k].master_owns = 1'b1;
        m[k].held = 0;
        m[k].grants = (m[k].grants < cmax_of(k)) ? m[k].grants + 1 : m[k].grants;
      end else if (m[k].gap_left > 0) begin
        m[k].gap_left--;
      end
    end
    m[k].hist = {m[k].hist[6:0], ~nBUSREQ};
  endtask

  // Model update on every clock edge or asynchronous reset
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (checks_on) begin
      check("a.nBUSACK", int'(nbusack_a), int'(!m[0].master_owns));
      check("a.bus_float", int'(float_a), int'(m[0].master_owns));
      check("a.core_stall", int'(stall_a), int'(exp_stall(0, mcycle_done)));
      check("a.grant_count", int'(count_a), m[0].grants);
      check("a.timeout", int'(timeout_a), int'(m[0].overlong));
      check("b.nBUSACK", int'(nbusack_b), int'(!m[1].master_owns));
      check("b.bus_float", int'(float_b), int'(m[1].master_owns));
      check("b.core_stall", int'(stall_b), int'(exp_stall(1, mcycle_done)));
      check("b.grant_count", int'(count_b), m[1].grants);
      check("b.timeout", int'(timeout_b), int'(m[1].overlong));
    end
  end

  // One clock cycle with given inputs; returns just after the edge
  task automatic cyc(input logic rq_n, input logic md);
    nBUSREQ = rq_n;
    mcycle_done = md;
    @(negedge CLK);
    stall_a_c = stall_a;
    stall_b_c = stall_b;
    @(posedge CLK);
    #1;
  endtask

  task automatic release_a(output int n);
    n = 0;
    do begin
      cyc(1'b1, 1'b0);
      n++;
    end while (nbusack_a === 1'b0 && n < 10);
    if (n >= 10) check("release_bound", 0, 1);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    nRESET = 1'b1;
    checks_on = 1'b1;
    check("rst.nBUSACK", int'(nbusack_a), 1);
    check("rst.bus_float", int'(float_a), 0);
    check("rst.grant_count", int'(count_a), 0);

    // Basic grant: request from before edge 0, boundaries at cycles 1 and 5
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("basic.c1_stall", int'(stall_a_c), 0);
    check("basic.c1_nBUSACK", int'(nbusack_a), 1);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("basic.c5_stall", int'(stall_a_c), 1);
    check("basic.nBUSACK", int'(nbusack_a), 0);
    check("basic.bus_float", int'(float_a), 1);
    check("basic.grant_count", int'(count_a), 1);

    // Release: synchronizer latency plus one decision edge
    release_a(n);
    check("rel.edges", n, SYNC + 1);
    check("rel.bus_float", int'(float_a), 0);
    cyc(1'b1, 1'b0);
    check("rel.stall_turnaround", int'(stall_a_c), 1);
    cyc(1'b1, 1'b0);
    check("rel.stall_idle", int'(stall_a_c), 0);

    // Gap on dut_b (MIN_CPU_GAP=2): third boundary after release grants
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("gap.p1_stall_b", int'(stall_b_c), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("gap.p2_stall_b", int'(stall_b_c), 0);
    check("gap.p2_count_b", int'(count_b), 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("gap.p3_stall_b", int'(stall_b_c), 1);
    check("gap.p3_count_b", int'(count_b), 2);
    check("gap.p3_nBUSACK_b", int'(nbusack_b), 0);

    // Asynchronous reset mid-grant, observed without a clock edge
    check("mid.nBUSACK_before", int'(nbusack_a), 0);
    mcycle_done = 1'b1;
    nRESET = 1'b0;
    #1;
    check("mid.nBUSACK", int'(nbusack_a), 1);
    check("mid.bus_float", int'(float_a), 0);
    check("mid.core_stall", int'(stall_a), 0);
    check("mid.grant_count", int'(count_a), 0);
    check("mid.timeout", int'(timeout_a), 0);
    check("mid.count_b", int'(count_b), 0);
    #2;
    nRESET = 1'b1;
    mcycle_done = 1'b0;

    // Five grant/release sequences; the first one is held long for timeout
    for (int g = 1; g <= 5; g++) begin
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      check("sat.stall", int'(stall_a_c), 1);
      check("sat.grant_count", int'(count_a), (g < 3) ? g : 3);
      if (g == 1) begin
        for (int i = 1; i <= 20; i++) begin
          cyc(1'b0, 1'b0);
          check("tmo.timeout", int'(timeout_a), (i >= A_MAX) ? 1 : 0);
          check("tmo.nBUSACK", int'(nbusack_a), 0);
        end
      end else begin
        cyc(1'b0, 1'b0);
      end
      release_a(n);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      if (g == 1) check("tmo.sticky", int'(timeout_a), 1);
    end

    // Request drops on the very edge that commits the grant
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("min.stall", int'(stall_a_c), 1);
    check("min.nBUSACK_grant", int'(nbusack_a), 0);
    cyc(1'b1, 1'b0);
    check("min.nBUSACK_release", int'(nbusack_a), 1);
    check("min.bus_float", int'(float_a), 0);
    repeat (3) cyc(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout_guard: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
